// File: rtl/i2s_audio_in_pkg.sv
// Shared definitions for the I2S capture path.
// WORD_DEFAULT : bck periods (data bits) per channel slot, MSB first.
// state_t      : slot-tracking states of the receiver.
// Frame layout, shared with the transmitter: {right, left}. The left sample
// occupies [WORD-1:0] and the right sample occupies [2*WORD-1:WORD].
package i2s_audio_in_pkg;

  localparam int unsigned WORD_DEFAULT = 32;

  typedef enum logic [1:0] {
    STATE_HUNT  = 2'd0,
    STATE_LEFT  = 2'd1,
    STATE_RIGHT = 2'd2
  } state_t;

endpackage

// File: rtl/i2s_audio_in_fifo.sv
// audio_in_fifo: show-ahead synchronous FIFO for captured stereo frames.
// clk, aclr        : clock, asynchronous active-high reset
// wrreq, data      : push a frame (accepted when not full, or when full with a
//                    pop in the same cycle)
// rdreq            : pop the head frame (ignored when rdempty=1)
// q                : head frame, valid while rdempty=0, zero otherwise
// rdempty, full    : occupancy flags
module audio_in_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             rdempty,
  output logic             full
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic             wr_en;
  logic             rd_en;

  assign rdempty = (count == '0);
  assign full    = (count == CNT_FULL);
  assign rd_en   = rdreq & ~rdempty;
  assign wr_en   = wrreq & (~full | rd_en);
  assign q       = rdempty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2s_audio_in.sv
// i2s_audio_in: I2S slave receiver.
// clk, aclr     : system clock (>= 8x bck), asynchronous active-high reset
// bck, lrck, din: I2S pins, asynchronous to clk (lrck 0 = left, 1 = right)
// rdreq         : pop the head frame
// sample        : head frame {right, left}, valid while rdempty=0
// rdempty       : no frame buffered
// overrun       : sticky, a complete frame was dropped because the FIFO was full
// frame_err     : sticky, a slot with a bit count other than WORD was seen
// err_clr       : synchronous clear of both sticky flags (a set in the same
//                 cycle wins)
module i2s_audio_in
  import i2s_audio_in_pkg::*;
#(
  parameter int unsigned WORD  = WORD_DEFAULT,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              bck,
  input  logic              lrck,
  input  logic              din,
  input  logic              rdreq,
  output logic [2*WORD-1:0] sample,
  output logic              rdempty,
  output logic              overrun,
  output logic              frame_err,
  input  logic              err_clr
);

  localparam int unsigned CW = $clog2(WORD + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WORD);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WORD + 1);

  logic [2:0]        bck_s;
  logic [2:0]        lrck_s;
  logic [2:0]        din_s;
  logic              bck_rise;
  logic              lrck_a;
  logic              din_a;

  state_t            state;
  logic              lrck_prev;
  logic [CW-1:0]     bit_cnt;
  logic [CW-1:0]     cnt_next;
  logic [WORD-1:0]   shift_q;
  logic [WORD-1:0]   word_now;
  logic [WORD-1:0]   left_q;
  logic              slot_full;
  logic              push_q;
  logic [2*WORD-1:0] frame_q;

  logic              fifo_full;
  logic              pop;

  // Two synchroniser stages, then a third stage. lrck/din go through the same
  // depth so their third-stage values line up with the registered rise pulse.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      bck_s    <= '0;
      lrck_s   <= '0;
      din_s    <= '0;
      bck_rise <= 1'b0;
    end else begin
      bck_s    <= {bck_s[1:0], bck};
      lrck_s   <= {lrck_s[1:0], lrck};
      din_s    <= {din_s[1:0], din};
      bck_rise <= bck_s[1] & ~bck_s[2];
    end
  end

  assign lrck_a = lrck_s[2];
  assign din_a  = din_s[2];

  // The bit taken on an lrck-change rise is the LSB of the slot that just
  // ended, so the completed word and its length both include this bit.
  assign word_now  = {shift_q[WORD-2:0], din_a};
  assign cnt_next  = (bit_cnt == CNT_SAT) ? bit_cnt : bit_cnt + 1'b1;
  assign slot_full = (cnt_next == CNT_FULL);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state     <= STATE_HUNT;
      lrck_prev <= 1'b1;
      bit_cnt   <= '0;
      shift_q   <= '0;
      left_q    <= '0;
      push_q    <= 1'b0;
      frame_q   <= '0;
      frame_err <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (err_clr) frame_err <= 1'b0;
      if (bck_rise) begin
        shift_q   <= word_now;
        lrck_prev <= lrck_a;
        if (lrck_a != lrck_prev) begin
          bit_cnt <= '0;
          case (state)
            STATE_HUNT: begin
              if (!lrck_a) state <= STATE_LEFT;
            end
            STATE_LEFT: begin
              if (slot_full) begin
                left_q <= word_now;
                state  <= STATE_RIGHT;
              end else begin
                frame_err <= 1'b1;
                state     <= STATE_HUNT;
              end
            end
            STATE_RIGHT: begin
              if (slot_full) begin
                push_q  <= 1'b1;
                frame_q <= {word_now, left_q};
                state   <= STATE_LEFT;
              end else begin
                frame_err <= 1'b1;
                state     <= STATE_HUNT;
              end
            end
            default: state <= STATE_HUNT;
          endcase
        end else begin
          bit_cnt <= cnt_next;
        end
      end
    end
  end

  assign pop = rdreq & ~rdempty;

  // A push into a full FIFO is only dropped when no pop frees a slot that cycle.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      overrun <= 1'b0;
    end else if (push_q & fifo_full & ~pop) begin
      overrun <= 1'b1;
    end else if (err_clr) begin
      overrun <= 1'b0;
    end
  end

  audio_in_fifo #(
    .WIDTH(2 * WORD),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .aclr   (aclr),
    .wrreq  (push_q),
    .data   (frame_q),
    .rdreq  (rdreq),
    .q      (sample),
    .rdempty(rdempty),
    .full   (fifo_full)
  );

endmodule

// File: tb/tb_i2s_audio_in.sv
// Self-checking bench for i2s_audio_in: serialises I2S frames from a bit queue
// and compares the FIFO output against a scoreboard of whole frames.
module tb_i2s_audio_in;

  localparam int unsigned WORD = 32;

  logic        clk = 1'b0;
  logic        aclr = 1'b0;
  logic        bck = 1'b0;
  logic        lrck = 1'b1;
  logic        din = 1'b0;
  logic        rdreq = 1'b0;
  logic        err_clr = 1'b0;
  logic [63:0] sample;
  logic        rdempty;
  logic        overrun;
  logic        frame_err;

  int npass = 0;
  int nfail = 0;
  int ntotal = 0;

  logic        lq[$];
  logic        dq[$];
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  i2s_audio_in #(.WORD(WORD), .DEPTH(4)) dut (
    .clk      (clk),
    .aclr     (aclr),
    .bck      (bck),
    .lrck     (lrck),
    .din      (din),
    .rdreq    (rdreq),
    .sample   (sample),
    .rdempty  (rdempty),
    .overrun  (overrun),
    .frame_err(frame_err),
    .err_clr  (err_clr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntotal++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic add_slot(input logic l, input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      lq.push_back(l);
      dq.push_back(v[i]);
    end
  endtask

  task automatic add_frame(input logic [31:0] lw, input logic [31:0] rw, input bit keep);
    add_slot(1'b0, lw, 32);
    add_slot(1'b1, rw, 32);
    if (keep) sb.push_back({rw, lw});
  endtask

  // lrck leads din by one bit: it shows the slot of the following bit.
  task automatic send(input bit chk_lat, input bit pop_last);
    int n;
    n = lq.size();
    for (int k = 0; k < n; k++) begin
      bck  = 1'b0;
      din  = dq[k];
      lrck = (k + 1 < n) ? lq[k+1] : 1'b0;
      repeat (4) @(negedge clk);
      bck = 1'b1;
      if (k + 1 == n && (chk_lat || pop_last)) begin
        repeat (4) @(negedge clk);
        if (chk_lat) chk("empty_3clk_after_lsb", rdempty, 1'b1);
        if (pop_last) begin
          chk("head_before_pushpop", sample, sb[0]);
          rdreq = 1'b1;
        end
        @(negedge clk);
        rdreq = 1'b0;
        if (chk_lat) begin
          chk("nonempty_4clk_after_lsb", rdempty, 1'b0);
          chk("sample_4clk_after_lsb", sample, sb[0]);
        end
        if (pop_last) void'(sb.pop_front());
      end else begin
        repeat (4) @(negedge clk);
      end
    end
    bck = 1'b0;
    lq.delete();
    dq.delete();
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    bck  = 1'b0;
    lrck = 1'b1;
    din  = 1'b0;
    @(negedge clk);
    aclr = 1'b1;
    @(negedge clk);
    aclr = 1'b0;
    sb.delete();
    @(negedge clk);
  endtask

  task automatic read_all(input string tag);
    int n;
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_notempty"}, rdempty, 1'b0);
      chk(tag, sample, sb.pop_front());
      rdreq = 1'b1;
      @(negedge clk);
      rdreq = 1'b0;
    end
    chk({tag, "_drained"}, rdempty, 1'b1);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] v;

    // Reset values, then the fixed pattern with a partial right slot lead-in.
    do_reset();
    chk("rst_sample", sample, 64'h0);
    chk("rst_rdempty", rdempty, 1'b1);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    add_slot(1'b1, $urandom, 7);
    add_frame(32'h12345678, 32'h9ABCDEF0, 1'b1);
    send(1'b1, 1'b0);
    chk("fixed_frame", sample, 64'h9ABCDEF0_12345678);
    add_frame($urandom, $urandom, 1'b1);
    add_frame($urandom, $urandom, 1'b1);
    send(1'b0, 1'b0);
    chk("leadin_no_frame_err", frame_err, 1'b0);
    read_all("basic_read");
    chk("basic_no_overrun", overrun, 1'b0);

    // Five frames into a four-deep FIFO with no reads.
    do_reset();
    add_slot(1'b1, $urandom, 3);
    for (int i = 0; i < 5; i++) add_frame($urandom, $urandom, i < 4);
    send(1'b0, 1'b0);
    chk("overrun_set", overrun, 1'b1);
    read_all("overrun_read");
    chk("overrun_sticky", overrun, 1'b1);
    pulse_clr();
    chk("overrun_cleared", overrun, 1'b0);

    // Short left slot, then a proper frame after resync.
    do_reset();
    add_slot(1'b1, $urandom, 5);
    add_slot(1'b0, $urandom, 31);
    add_slot(1'b1, $urandom, 32);
    add_frame($urandom, $urandom, 1'b1);
    send(1'b0, 1'b0);
    chk("short_slot_frame_err", frame_err, 1'b1);
    read_all("resync_read");
    pulse_clr();
    chk("frame_err_cleared", frame_err, 1'b0);

    // Full FIFO with push and pop in the same cycle.
    do_reset();
    add_slot(1'b1, $urandom, 4);
    for (int i = 0; i < 5; i++) add_frame($urandom, $urandom, 1'b1);
    send(1'b0, 1'b1);
    chk("pushpop_no_overrun", overrun, 1'b0);
    read_all("pushpop_read");

    // Reset in the middle of a left slot.
    do_reset();
    add_slot(1'b1, $urandom, 6);
    add_frame($urandom, $urandom, 1'b1);
    v = $urandom;
    add_slot(1'b0, {22'b0, v[31:22]}, 10);
    send(1'b0, 1'b0);
    chk("pre_reset_nonempty", rdempty, 1'b0);
    aclr = 1'b1;
    @(negedge clk);
    chk("midrst_sample", sample, 64'h0);
    chk("midrst_rdempty", rdempty, 1'b1);
    chk("midrst_overrun", overrun, 1'b0);
    chk("midrst_frame_err", frame_err, 1'b0);
    aclr = 1'b0;
    sb.delete();
    @(negedge clk);
    add_slot(1'b0, {10'b0, v[21:0]}, 22);
    add_slot(1'b1, $urandom, 32);
    add_frame($urandom, $urandom, 1'b1);
    add_frame($urandom, $urandom, 1'b1);
    send(1'b0, 1'b0);
    read_all("post_rst_read");
    pulse_clr();
    chk("post_rst_flags_clear", {overrun, frame_err}, 2'b00);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
